// File: rtl/fp_adder_arbiter.sv
// Two-client request/ack front end sharing one combinational IEEE-754 single-precision adder.
// Operands are captured on the grant edge; each result lands on the winning client's port with its ack pulse.
module fp_adder_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req0,
  input  logic [31:0]      a0,
  input  logic [31:0]      b0,
  output logic             ack0,
  output logic [31:0]      r0,
  input  logic             req1,
  input  logic [31:0]      a1,
  input  logic [31:0]      b1,
  output logic             ack1,
  output logic [31:0]      r1,
  output logic             busy,
  output logic             gnt,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]  state_r;
  logic [31:0] opa_r;
  logic [31:0] opb_r;
  logic        last_gnt_r;

  logic        any_req_s;
  logic        win_s;
  logic [31:0] sum_s;

  logic [31:0] big_s;
  logic [31:0] small_s;
  logic [7:0]  be_s;
  logic [7:0]  se_s;
  logic [7:0]  shift_s;
  logic [26:0] bm_s;
  logic [26:0] sm_s;
  logic [26:0] sm_al_s;
  logic [26:0] mag_s;
  logic [27:0] wide_s;
  logic [9:0]  exp_s;
  logic [24:0] rounded_s;
  logic        sticky_s;
  logic        rnd_up_s;
  logic        is_sub_s;
  logic        nan_s;

  // Arbitration: a tie goes to the client not served last, unless fixed priority is selected
  always_comb begin
    any_req_s = req0 | req1;
    if (req0 && req1) begin
      win_s = RR_EN ? ~last_gnt_r : 1'b0;
    end else if (req1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  // Adder datapath: align, add/subtract, normalise, round-to-nearest-even
  always_comb begin
    if (opb_r[30:0] > opa_r[30:0]) begin
      big_s   = opb_r;
      small_s = opa_r;
    end else begin
      big_s   = opa_r;
      small_s = opb_r;
    end
    nan_s = ((&opa_r[30:23]) && (|opa_r[22:0])) ||
            ((&opb_r[30:23]) && (|opb_r[22:0])) ||
            ((&opa_r[30:23]) && (&opb_r[30:23]) && (opa_r[31] != opb_r[31]));
    // Denormals carry an effective exponent of 1 and no hidden bit
    be_s    = (big_s[30:23] == 8'd0) ? 8'd1 : big_s[30:23];
    se_s    = (small_s[30:23] == 8'd0) ? 8'd1 : small_s[30:23];
    bm_s    = {(big_s[30:23] != 8'd0), big_s[22:0], 3'b000};
    sm_s    = {(small_s[30:23] != 8'd0), small_s[22:0], 3'b000};
    shift_s = be_s - se_s;
    sticky_s = 1'b0;
    for (int i = 0; i < 27; i++) begin
      sticky_s = sticky_s | (sm_s[i] & (8'(i) < shift_s));
    end
    sm_al_s    = (shift_s > 8'd26) ? 27'd0 : (sm_s >> shift_s);
    sm_al_s[0] = sm_al_s[0] | sticky_s;
    is_sub_s   = big_s[31] ^ small_s[31];
    exp_s      = {2'b00, be_s};
    wide_s     = 28'd0;
    if (is_sub_s) begin
      mag_s = bm_s - sm_al_s;
    end else begin
      wide_s = {1'b0, bm_s} + {1'b0, sm_al_s};
      if (wide_s[27]) begin
        mag_s = {wide_s[27:2], wide_s[1] | wide_s[0]};
        exp_s = exp_s + 10'd1;
      end else begin
        mag_s = wide_s[26:0];
      end
    end
    // Left-normalise, stopping at the denormal floor
    for (int i = 0; i < 26; i++) begin
      if (!mag_s[26] && (exp_s > 10'd1)) begin
        mag_s = mag_s << 1;
        exp_s = exp_s - 10'd1;
      end else begin
        mag_s = mag_s;
        exp_s = exp_s;
      end
    end
    rnd_up_s  = mag_s[2] & (mag_s[1] | mag_s[0] | mag_s[3]);
    rounded_s = {1'b0, mag_s[26:3]} + {24'd0, rnd_up_s};
    if (rounded_s[24]) begin
      rounded_s = rounded_s >> 1;
      exp_s     = exp_s + 10'd1;
    end else begin
      rounded_s = rounded_s;
    end
    if (nan_s) begin
      sum_s = 32'h7FC0_0000;
    end else if (&big_s[30:23]) begin
      sum_s = big_s;
    end else if (is_sub_s && (mag_s == 27'd0)) begin
      sum_s = 32'd0;
    end else if (exp_s >= 10'd255) begin
      sum_s = {big_s[31], 8'hFF, 23'd0};
    end else begin
      sum_s = {big_s[31], (rounded_s[23] ? exp_s[7:0] : 8'd0), rounded_s[22:0]};
    end
  end

  // Sequencer: grant, evaluate, respond; reset aborts any operation in flight
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= IDLE;
      opa_r      <= 32'd0;
      opb_r      <= 32'd0;
      last_gnt_r <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      r0         <= 32'd0;
      r1         <= 32'd0;
      busy       <= 1'b0;
      gnt        <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            opa_r   <= win_s ? a1 : a0;
            opb_r   <= win_s ? b1 : b0;
            gnt     <= win_s;
            busy    <= 1'b1;
            state_r <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (gnt) begin
            r1   <= sum_s;
            ack1 <= 1'b1;
          end else begin
            r0   <= sum_s;
            ack0 <= 1'b1;
          end
          state_r <= RESP;
        end
        RESP: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          busy       <= 1'b0;
          last_gnt_r <= gnt;
          op_count   <= op_count + CNT_W'(1);
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: three instances (round-robin, fixed priority, 2-bit counter)
// share operands; each has its own request-driving clients and a cycle-level reference model.
module tb_fp_adder_arbiter;
  logic        clk = 1'b0;
  logic        nreset;
  logic [31:0] a0, b0, a1, b1;
  logic        req0_v [3];
  logic        req1_v [3];
  logic        ack0_v [3];
  logic        ack1_v [3];
  logic        busy_v [3];
  logic        gnt_v  [3];
  logic [31:0] r0_v   [3];
  logic [31:0] r1_v   [3];
  logic [15:0] oc_a, oc_b;
  logic [1:0]  oc_c;

  int total = 0;
  int bad   = 0;

  bit rr_c [3] = '{1'b1, 1'b0, 1'b1};
  int cw_c [3] = '{16, 16, 2};

  always #5 clk = ~clk;

  fp_adder_arbiter #(.RR_EN(1'b1), .CNT_W(16)) u_rr (
    .clk(clk), .nreset(nreset),
    .req0(req0_v[0]), .a0(a0), .b0(b0), .ack0(ack0_v[0]), .r0(r0_v[0]),
    .req1(req1_v[0]), .a1(a1), .b1(b1), .ack1(ack1_v[0]), .r1(r1_v[0]),
    .busy(busy_v[0]), .gnt(gnt_v[0]), .op_count(oc_a));
  fp_adder_arbiter #(.RR_EN(1'b0), .CNT_W(16)) u_fix (
    .clk(clk), .nreset(nreset),
    .req0(req0_v[1]), .a0(a0), .b0(b0), .ack0(ack0_v[1]), .r0(r0_v[1]),
    .req1(req1_v[1]), .a1(a1), .b1(b1), .ack1(ack1_v[1]), .r1(r1_v[1]),
    .busy(busy_v[1]), .gnt(gnt_v[1]), .op_count(oc_b));
  fp_adder_arbiter #(.RR_EN(1'b1), .CNT_W(2)) u_wrap (
    .clk(clk), .nreset(nreset),
    .req0(req0_v[2]), .a0(a0), .b0(b0), .ack0(ack0_v[2]), .r0(r0_v[2]),
    .req1(req1_v[2]), .a1(a1), .b1(b1), .ack1(ack1_v[2]), .r1(r1_v[2]),
    .busy(busy_v[2]), .gnt(gnt_v[2]), .op_count(oc_c));

  // Reference sum via real arithmetic (vectors are exactly representable)
  function automatic real f2r(logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(real x);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(x);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] ref_add(logic [31:0] x, logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction

  function automatic int oc(int i);
    if (i == 0) return int'(oc_a);
    if (i == 1) return int'(oc_b);
    return int'(oc_c);
  endfunction

  // Model: elapsed cycles since grant decide ack, result and idle points
  int          cyc = 0;
  bit          act_m   [3];
  int          gat_m   [3];
  bit          who_m   [3];
  bit          last_m  [3];
  int          cnt_m   [3];
  bit          eack0_m [3];
  bit          eack1_m [3];
  bit          ebusy_m [3];
  bit          egnt_m  [3];
  logic [31:0] er0_m   [3];
  logic [31:0] er1_m   [3];
  logic [31:0] esum_m  [3];

  function automatic bit pick(int i);
    if (req0_v[i] && req1_v[i]) return rr_c[i] ? !last_m[i] : 1'b0;
    return req1_v[i];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 3; i++) begin
        act_m[i] <= 1'b0; last_m[i] <= 1'b1; cnt_m[i] <= 0;
        eack0_m[i] <= 1'b0; eack1_m[i] <= 1'b0; ebusy_m[i] <= 1'b0; egnt_m[i] <= 1'b0;
        er0_m[i] <= 32'd0; er1_m[i] <= 32'd0; gat_m[i] <= 0; who_m[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (act_m[i] && cyc == gat_m[i] + 1) begin
          if (who_m[i]) begin eack1_m[i] <= 1'b1; er1_m[i] <= esum_m[i]; end
          else begin eack0_m[i] <= 1'b1; er0_m[i] <= esum_m[i]; end
        end else if (act_m[i] && cyc == gat_m[i] + 2) begin
          eack0_m[i] <= 1'b0; eack1_m[i] <= 1'b0; ebusy_m[i] <= 1'b0;
          last_m[i] <= who_m[i]; cnt_m[i] <= cnt_m[i] + 1; act_m[i] <= 1'b0;
        end else if (!act_m[i] && (req0_v[i] || req1_v[i])) begin
          who_m[i] <= pick(i); egnt_m[i] <= pick(i); gat_m[i] <= cyc;
          act_m[i] <= 1'b1; ebusy_m[i] <= 1'b1;
          esum_m[i] <= pick(i) ? ref_add(a1, b1) : ref_add(a0, b0);
        end
      end
    end
  end

  // Client bookkeeping (only the main process touches these)
  int tgt0 [3], tgt1 [3], done0 [3], done1 [3];
  int ack0_cyc [3], ack1_cyc [3], rise0_cyc [3], snap0 [3];
  int log_oc [8];
  int nlog = 0;
  bit log_on = 1'b0;
  bit prev_ack_c = 1'b0;

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk("ack0", i, ack0_v[i], eack0_m[i]);
      chk("ack1", i, ack1_v[i], eack1_m[i]);
      chk("r0", i, r0_v[i], er0_m[i]);
      chk("r1", i, r1_v[i], er1_m[i]);
      chk("busy", i, busy_v[i], ebusy_m[i]);
      chk("gnt", i, gnt_v[i], egnt_m[i]);
      chk("op_count", i, oc(i), cnt_m[i] % (1 << cw_c[i]));
    end
  endtask

  task automatic tick();
    bit nr;
    @(negedge clk);
    if (nreset) compare_all();
    if (log_on && prev_ack_c && nlog < 8) begin log_oc[nlog] = int'(oc_c); nlog++; end
    prev_ack_c = ack0_v[2] | ack1_v[2];
    for (int i = 0; i < 3; i++) begin
      if (ack0_v[i]) begin done0[i]++; ack0_cyc[i] = cyc; end
      if (ack1_v[i]) begin done1[i]++; ack1_cyc[i] = cyc; snap0[i] = done0[i]; end
      nr = done0[i] < tgt0[i];
      if (nr && !req0_v[i]) rise0_cyc[i] = cyc;
      req0_v[i] = nr;
      req1_v[i] = done1[i] < tgt1[i];
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < 3; i++) begin
      if (done0[i] != tgt0[i] || done1[i] != tgt1[i] || act_m[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_done(string name);
    int n = 0;
    while (!all_done() && n < 200) begin tick(); n++; end
    chk(name, 0, n < 200, 1'b1);
  endtask

  task automatic add_ops(int n0, int n1);
    for (int i = 0; i < 3; i++) begin tgt0[i] += n0; tgt1[i] += n1; end
  endtask

  task automatic chk_reset_vals(string name);
    for (int i = 0; i < 3; i++) begin
      chk({name, "_ack"}, i, {31'd0, ack0_v[i] | ack1_v[i]}, 32'd0);
      chk({name, "_r0"}, i, r0_v[i], 32'd0);
      chk({name, "_r1"}, i, r1_v[i], 32'd0);
      chk({name, "_busy"}, i, busy_v[i], 1'b0);
      chk({name, "_gnt"}, i, gnt_v[i], 1'b0);
      chk({name, "_cnt"}, i, oc(i), 0);
    end
  endtask

  initial begin
    int base0, base_oc, n, sn [3];
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    nreset = 1'b0;
    a0 = 32'd0; b0 = 32'd0; a1 = 32'd0; b1 = 32'd0;
    for (int i = 0; i < 3; i++) begin
      req0_v[i] = 1'b0; req1_v[i] = 1'b0;
      tgt0[i] = 0; tgt1[i] = 0; done0[i] = 0; done1[i] = 0;
    end
    repeat (2) tick();
    chk_reset_vals("reset");
    nreset = 1'b1;
    tick();

    // Single op on client 0: 3.5 + 3.0
    a0 = 32'h4060_0000; b0 = 32'h4040_0000;
    add_ops(1, 0);
    wait_done("single_timeout");
    chk("single_r0", 0, r0_v[0], 32'h40D0_0000);
    chk("single_cnt", 0, oc(0), 1);
    chk("single_lat", 0, ack0_cyc[0] - rise0_cyc[0], 2);
    chk("single_no_ack1", 0, done1[0], 0);

    // Mixed sign on client 1: 7.0 + -4.25
    a1 = 32'h40E0_0000; b1 = 32'hC088_0000;
    add_ops(0, 1);
    wait_done("mixed_timeout");
    chk("mixed_r1", 0, r1_v[0], 32'h4030_0000);
    chk("mixed_r0_held", 0, r0_v[0], 32'h40D0_0000);

    // Simultaneous: 5.5 + 4.25 and 3.5 + 3.0
    a0 = 32'h40B0_0000; b0 = 32'h4088_0000; a1 = 32'h4060_0000; b1 = 32'h4040_0000;
    add_ops(1, 1);
    wait_done("simul_timeout");
    chk("simul_r0", 0, r0_v[0], 32'h411C_0000);
    chk("simul_r1", 0, r1_v[0], 32'h40D0_0000);
    chk("simul_gap", 0, ack1_cyc[0] - ack0_cyc[0], 3);

    // Persistent ties: round-robin alternates, fixed priority starves client 1
    add_ops(3, 3);
    wait_done("persist_timeout");
    a0 = 32'h3F80_0000; b0 = 32'h4000_0000; a1 = 32'hBFC0_0000; b1 = 32'h3F00_0000;
    base0 = done0[1]; base_oc = oc(1);
    for (int i = 0; i < 3; i++) sn[i] = done0[i];
    add_ops(4, 1);
    wait_done("fixed_timeout");
    chk("fixed_first_ack1", 1, snap0[1] - base0, 4);
    chk("rr_first_ack1", 0, snap0[0] - sn[0], 1);
    chk("fixed_cnt", 1, oc(1) - base_oc, 5);
    chk("fixed_r0", 1, r0_v[1], 32'h4040_0000);
    chk("fixed_r1", 1, r1_v[1], 32'hBF80_0000);

    // Reset during ISSUE aborts the operation
    a0 = 32'h4060_0000; b0 = 32'h4040_0000;
    for (int i = 0; i < 3; i++) sn[i] = done0[i];
    add_ops(1, 0);
    n = 0;
    while (!busy_v[0] && n < 20) begin tick(); n++; end
    chk("issue_seen", 0, busy_v[0], 1'b1);
    #1 nreset = 1'b0;
    #1 chk_reset_vals("midrst");
    for (int i = 0; i < 3; i++) tgt0[i] = done0[i];
    repeat (2) tick();
    nreset = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk("midrst_no_ack", i, done0[i] - sn[i], 0);

    // Five ops after reset: 2-bit counter reads 1,2,3,0,1
    log_on = 1'b1;
    add_ops(5, 0);
    wait_done("wrap_timeout");
    tick();
    log_on = 1'b0;
    chk("wrap_len", 2, nlog, 5);
    for (int k = 0; k < 5; k++) chk("wrap_seq", k, log_oc[k], wrap_exp[k]);
    chk("wrap_r0", 2, r0_v[2], 32'h40D0_0000);
    chk("post_rst_cnt", 0, oc(0), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
